arp_protocol_cached: RTL and testbench
======================================

Name: arp_protocol_cached

Overview:
Next-generation ARP engine, replacing the stateless responder.
- Replies to ARP requests for our IP, emitting the reply on the L2 TX bus in lockstep with RX.
- Learns IP-to-MAC bindings from valid requests and replies into a DEPTH-entry cache.
- Serves single-cycle lookups to the IPv4 TX path.
- Sits between the Ethernet RX L2 decoder and the L2 TX arbiter.

Parameters:
DEPTH, 8, number of cache entries; power of 2, at least 2.
MAX_AGE, 300, age_tick pulses before an entry expires; used only with ARP_AGING_EN.

Ports:
clk  in  1  single clock for all logic
rst_n  in  1  synchronous, active-low reset
our_mac_address  in  48  our MAC
our_ip_address  in  32  our IPv4 address
our_subnet_mask  in  32  learning filter mask
rx_l2_bus  in  EthernetBus  incoming L2 payload (start/data_valid/bytes_valid/data/commit/drop)
rx_l2_headers_valid  in  1  L2 header decoded
rx_l2_ethertype_is_arp  in  1  ethertype is 0x0806
tx_l2_bus  out  EthernetBus  outgoing reply payload
tx_l2_dst_mac  out  48  reply destination MAC
lookup_en  in  1  lookup request strobe
lookup_ip  in  32  IP to resolve
lookup_done  out  1  lookup result valid, one cycle after lookup_en
lookup_hit  out  1  entry found
lookup_mac  out  48  resolved MAC; 0 on miss
cache_flush  in  1  invalidate all entries
age_tick  in  1  aging time base pulse; ignored without ARP_AGING_EN

Behaviour:
Reset (rst_n low at a clk edge):
- All tx_l2_bus fields, tx_l2_dst_mac, and lookup_* outputs go to 0.
- RX FSM goes to IDLE.
- All cache valid bits clear; victim pointer goes to 0.

RX FSM: IDLE, L2_HEADER, BODY_0..BODY_6, COMMIT, LEARN.
- IDLE -> L2_HEADER on start.
- L2_HEADER:
  - headers_valid with ARP ethertype -> BODY_0.
  - Any other ethertype -> pulse tx drop, go to IDLE.
- BODY_0..BODY_6: one per 4-byte word, advancing only on data_valid.
  - Word 0 must equal 0x00010800.
  - Word 1 [31:16] must equal 0x0604; OPER must be 1 or 2.
  - Any other value, or bytes_valid!=4, -> drop, go to IDLE.
- Reply (requests only): each reply word is driven 1 cycle after the matching RX word.
  - Reply words in order: 0x00010800; 0x06040002; MAC[47:16]; {MAC[15:0], IP[31:16]}; {IP[15:0], SHA[47:32]}; SHA[31:0]; SPA.
  - bytes_valid is always 4.
  - tx_l2_dst_mac is set to SHA in BODY_4.
  - OPER=2: pulse tx drop immediately and suppress all reply words.
- tx start and tx drop mirror RX with 1-cycle delay.
- COMMIT:
  - TPA != our IP with a request: pulse tx drop immediately.
  - On rx commit: pulse tx commit (request to us only), then go to LEARN if learn-eligible, else IDLE.
  - Trailing padding words are ignored.
- rx drop in any state: go to IDLE, no learning.

Learn-eligible (all must hold):
- (SPA & mask) == (our IP & mask).
- SPA != 0.
- SPA != our IP.
- OPER=2, or OPER=1 with TPA == our IP.

LEARN: one cycle, then IDLE.
- SPA already present: overwrite its MAC in place.
- Otherwise write the lowest-index invalid entry.
- Cache full: write the entry at the victim pointer, then increment it modulo DEPTH.

Lookup:
- Parallel compare of lookup_ip against all valid entries.
- Result registered: lookup_done is high exactly 1 cycle after lookup_en; lookup_en is legal every cycle.
- Lookup in the same cycle as a LEARN write returns pre-write contents.

cache_flush:
- Clears all valid bits next cycle.
- Flush in the same cycle as LEARN: flush wins, nothing is stored.
- A lookup in the flush cycle still returns pre-flush contents.

Optional Feature:
ARP_AGING_EN.
- Defined:
  - Each entry has a counter of width $clog2(MAX_AGE+1), cleared on learn or refresh.
  - Counter increments on age_tick.
  - Entry is invalidated on the tick that brings it to MAX_AGE.
  - A learn in the same cycle as a tick wins.
- Undefined: no counters; age_tick is ignored; entries live until replaced or flushed.

Decomposition:
Package arp_pkg:
- ARP_OP_REQUEST, ARP_OP_REPLY.
- ARP_HTYPE_PTYPE (0x00010800), ARP_HLEN_PLEN (0x0604).
- RX state enum.
- arp_cache_entry_t struct {valid, ip[31:0], mac[47:0]}.

Sub-module arp_cache (DEPTH):
- Owns the entry array, learn/replace logic, lookup pipeline, flush and aging.
- Interface: learn_en/ip/mac, lookup port, flush, age_tick.

Test Plan:
- Request for our IP 10.0.0.5 from SHA 02:11:22:33:44:55, SPA 10.0.0.9 -> seven reply words as specified, dst MAC 02:11:22:33:44:55, tx commit; a lookup of 10.0.0.9 two cycles later hits with that MAC.
- Request targeting 10.0.0.7 -> tx drop at COMMIT, no commit; lookup of SPA misses.
- Reply from SPA 192.168.1.1 with mask 255.255.255.0 and our IP 10.0.0.5 -> no reply words, no learn; from 10.0.0.3 -> learned.
- DEPTH=8: learn 9 distinct IPs -> the 9th overwrites entry 0, the 10th overwrites entry 1; relearning an existing IP with a new MAC updates in place without moving the victim pointer.
- Truncated packet (bytes_valid=2 in BODY_3), or rx drop mid-body -> tx drop, FSM in IDLE, cache unchanged; rst_n low during BODY_5 -> all outputs 0, cache empty.
- ARP_AGING_EN with MAX_AGE=3: learn, then 3 age_tick pulses -> lookup misses; relearn on tick 2 -> still hits after tick 3.

Source files
------------

// File: rtl/arp_pkg.sv
// Shared ARP definitions: protocol constants, RX FSM state encoding and the
// cache entry layout used by arp_cache and arp_protocol_cached.
package arp_pkg;

  localparam logic [15:0] ARP_OP_REQUEST  = 16'h0001;
  localparam logic [15:0] ARP_OP_REPLY    = 16'h0002;
  localparam logic [31:0] ARP_HTYPE_PTYPE = 32'h0001_0800;
  localparam logic [15:0] ARP_HLEN_PLEN   = 16'h0604;

  // RX FSM states. BODY_0..BODY_6 are consecutive so the word index is
  // state - StBody0, and BODY_6 + 1 lands on StCommit.
  typedef logic [3:0] arp_rx_state_e;
  localparam arp_rx_state_e StIdle     = 4'd0;
  localparam arp_rx_state_e StL2Header = 4'd1;
  localparam arp_rx_state_e StBody0    = 4'd2;
  localparam arp_rx_state_e StBody1    = 4'd3;
  localparam arp_rx_state_e StBody2    = 4'd4;
  localparam arp_rx_state_e StBody3    = 4'd5;
  localparam arp_rx_state_e StBody4    = 4'd6;
  localparam arp_rx_state_e StBody5    = 4'd7;
  localparam arp_rx_state_e StBody6    = 4'd8;
  localparam arp_rx_state_e StCommit   = 4'd9;
  localparam arp_rx_state_e StLearn    = 4'd10;

  typedef struct packed {
    logic        valid;
    logic [31:0] ip;
    logic [47:0] mac;
  } arp_cache_entry_t;

endpackage

// File: rtl/arp_cache.sv
// IP-to-MAC binding cache for the ARP engine.
// Holds DEPTH entries. A learn overwrites a matching IP in place, otherwise
// fills the lowest free slot, otherwise replaces the round-robin victim.
// Lookups compare against all valid entries and return a registered result
// one cycle after lookup_en_i, always reflecting pre-write/pre-flush contents.
// Optional aging is built when the macro ARP_AGING_EN is defined.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   learn_en_i/ip_i/mac_i  write a binding (one cycle strobe)
//   lookup_en_i/ip_i       lookup request
//   lookup_done_o/hit_o/mac_o  registered lookup result (mac 0 on miss)
//   flush_i                invalidate all entries; beats a same-cycle learn
//   age_tick_i             aging time base (ignored without ARP_AGING_EN)
module arp_cache
  import arp_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned MAX_AGE = 300
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        learn_en_i,
  input  logic [31:0] learn_ip_i,
  input  logic [47:0] learn_mac_i,
  input  logic        lookup_en_i,
  input  logic [31:0] lookup_ip_i,
  output logic        lookup_done_o,
  output logic        lookup_hit_o,
  output logic [47:0] lookup_mac_o,
  input  logic        flush_i,
  input  logic        age_tick_i
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  arp_cache_entry_t entries_q [DEPTH];
  arp_cache_entry_t entries_d [DEPTH];
  logic [IdxW-1:0]  victim_q, victim_d;

  logic             done_q, hit_q;
  logic [47:0]      mac_q;

  logic             match_any, free_any;
  logic [IdxW-1:0]  match_idx, free_idx, wr_idx;
  logic             lk_hit;
  logic [47:0]      lk_mac;

`ifdef ARP_AGING_EN
  localparam int unsigned AgeW = $clog2(MAX_AGE + 1);
  logic [AgeW-1:0] age_q [DEPTH];
  logic [AgeW-1:0] age_d [DEPTH];
`else
  logic unused_age;
  assign unused_age = age_tick_i ^ (MAX_AGE == 0);
`endif

  // Slot selection for a learn: existing IP first, then lowest free slot.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entries_q[i].valid && entries_q[i].ip == learn_ip_i && !match_any) begin
        match_any = 1'b1;
        match_idx = IdxW'(i);
      end
      if (!entries_q[i].valid && !free_any) begin
        free_any = 1'b1;
        free_idx = IdxW'(i);
      end
    end
    if (match_any) begin
      wr_idx = match_idx;
    end else if (free_any) begin
      wr_idx = free_idx;
    end else begin
      wr_idx = victim_q;
    end
  end

  // IPs are unique in the cache, so OR-ing matching MACs yields the one hit.
  always_comb begin
    lk_hit = 1'b0;
    lk_mac = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entries_q[i].valid && entries_q[i].ip == lookup_ip_i) begin
        lk_hit = 1'b1;
        lk_mac = lk_mac | entries_q[i].mac;
      end
    end
  end

  always_comb begin
    entries_d = entries_q;
    victim_d  = victim_q;
`ifdef ARP_AGING_EN
    age_d     = age_q;
`endif
    if (flush_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_d[i].valid = 1'b0;
      end
    end else begin
`ifdef ARP_AGING_EN
      if (age_tick_i) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (entries_q[i].valid) begin
            if (age_q[i] == AgeW'(MAX_AGE - 1)) begin
              entries_d[i].valid = 1'b0;
              age_d[i]           = '0;
            end else begin
              age_d[i] = age_q[i] + 1'b1;
            end
          end
        end
      end
`endif
      // Applied after aging so a learn on a tick cycle wins.
      if (learn_en_i) begin
        entries_d[wr_idx].valid = 1'b1;
        entries_d[wr_idx].ip    = learn_ip_i;
        entries_d[wr_idx].mac   = learn_mac_i;
`ifdef ARP_AGING_EN
        age_d[wr_idx]           = '0;
`endif
        if (!match_any && !free_any) begin
          victim_d = victim_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
`ifdef ARP_AGING_EN
        age_q[i]     <= '0;
`endif
      end
      victim_q <= '0;
      done_q   <= 1'b0;
      hit_q    <= 1'b0;
      mac_q    <= '0;
    end else begin
      entries_q <= entries_d;
`ifdef ARP_AGING_EN
      age_q     <= age_d;
`endif
      victim_q  <= victim_d;
      done_q    <= lookup_en_i;
      hit_q     <= lookup_en_i & lk_hit;
      mac_q     <= lookup_en_i ? lk_mac : '0;
    end
  end

  assign lookup_done_o = done_q;
  assign lookup_hit_o  = hit_q;
  assign lookup_mac_o  = mac_q;

endmodule

// File: rtl/arp_protocol_cached.sv
// ARP engine: answers ARP requests for our IP on the L2 TX bus in lockstep
// with RX (one cycle behind), learns IP-to-MAC bindings into arp_cache and
// serves single-cycle lookups to the IPv4 TX path.
// Optional entry aging is enabled by defining ARP_AGING_EN.
//
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   our_mac/ip_address_i, our_subnet_mask_i  local identity, learn filter
//   rx_l2_bus_*_i                 RX payload bus (start/data_valid/bytes_valid/data/commit/drop)
//   rx_l2_headers_valid_i, rx_l2_ethertype_is_arp_i  L2 header decode
//   tx_l2_bus_*_o, tx_l2_dst_mac_o  reply payload bus and destination MAC
//   lookup_en_i/ip_i, lookup_done_o/hit_o/mac_o  cache lookup port
//   cache_flush_i, age_tick_i     cache maintenance
module arp_protocol_cached
  import arp_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned MAX_AGE = 300
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [47:0] our_mac_address_i,
  input  logic [31:0] our_ip_address_i,
  input  logic [31:0] our_subnet_mask_i,
  input  logic        rx_l2_bus_start_i,
  input  logic        rx_l2_bus_data_valid_i,
  input  logic [2:0]  rx_l2_bus_bytes_valid_i,
  input  logic [31:0] rx_l2_bus_data_i,
  input  logic        rx_l2_bus_commit_i,
  input  logic        rx_l2_bus_drop_i,
  input  logic        rx_l2_headers_valid_i,
  input  logic        rx_l2_ethertype_is_arp_i,
  output logic        tx_l2_bus_start_o,
  output logic        tx_l2_bus_data_valid_o,
  output logic [2:0]  tx_l2_bus_bytes_valid_o,
  output logic [31:0] tx_l2_bus_data_o,
  output logic        tx_l2_bus_commit_o,
  output logic        tx_l2_bus_drop_o,
  output logic [47:0] tx_l2_dst_mac_o,
  input  logic        lookup_en_i,
  input  logic [31:0] lookup_ip_i,
  output logic        lookup_done_o,
  output logic        lookup_hit_o,
  output logic [47:0] lookup_mac_o,
  input  logic        cache_flush_i,
  input  logic        age_tick_i
);

  arp_rx_state_e state_q, state_d;
  logic          req_q, req_d;        // packet is a request
  logic          dead_q, dead_d;      // reply already dropped for this packet
  logic          tpa_ok_q, tpa_ok_d;  // TPA equals our IP
  logic [47:0]   sha_q, sha_d;
  logic [31:0]   spa_q, spa_d;

  logic          tx_start_q, tx_start_d;
  logic          tx_dv_q, tx_dv_d;
  logic [2:0]    tx_bv_q, tx_bv_d;
  logic [31:0]   tx_data_q, tx_data_d;
  logic          tx_commit_q, tx_commit_d;
  logic          tx_drop_q, tx_drop_d;
  logic [47:0]   tx_dst_mac_q, tx_dst_mac_d;

  logic [2:0]    body_idx;
  logic [15:0]   oper;
  logic          word_ok, emit, abort, learn_ok;
  logic [31:0]   reply_word;

  assign body_idx = 3'(state_q - StBody0);
  assign oper     = rx_l2_bus_data_i[15:0];

  assign learn_ok = ((spa_q & our_subnet_mask_i) == (our_ip_address_i & our_subnet_mask_i))
                    && (spa_q != 32'd0) && (spa_q != our_ip_address_i)
                    && (!req_q || tpa_ok_q);

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    dead_d       = dead_q;
    tpa_ok_d     = tpa_ok_q;
    sha_d        = sha_q;
    spa_d        = spa_q;
    tx_start_d   = 1'b0;
    tx_dv_d      = 1'b0;
    tx_bv_d      = 3'd0;
    tx_data_d    = '0;
    tx_commit_d  = 1'b0;
    tx_drop_d    = 1'b0;
    tx_dst_mac_d = tx_dst_mac_q;
    word_ok      = 1'b1;
    emit         = 1'b0;
    reply_word   = '0;
    abort        = 1'b0;

    case (state_q)
      StIdle: begin
        if (rx_l2_bus_start_i) begin
          state_d    = StL2Header;
          tx_start_d = 1'b1;
          req_d      = 1'b0;
          dead_d     = 1'b0;
          tpa_ok_d   = 1'b0;
        end
      end
      StL2Header: begin
        if (rx_l2_headers_valid_i) begin
          if (rx_l2_ethertype_is_arp_i) begin
            state_d = StBody0;
          end else begin
            state_d   = StIdle;
            tx_drop_d = 1'b1;
          end
        end
      end
      StBody0, StBody1, StBody2, StBody3, StBody4, StBody5, StBody6: begin
        if (rx_l2_bus_data_valid_i) begin
          emit = req_q;
          case (body_idx)
            3'd0: begin
              // Word 0 leaves before OPER is known; a later drop cancels it.
              word_ok    = (rx_l2_bus_data_i == ARP_HTYPE_PTYPE);
              emit       = 1'b1;
              reply_word = ARP_HTYPE_PTYPE;
            end
            3'd1: begin
              word_ok    = (rx_l2_bus_data_i[31:16] == ARP_HLEN_PLEN)
                           && (oper == ARP_OP_REQUEST || oper == ARP_OP_REPLY);
              emit       = (oper == ARP_OP_REQUEST);
              reply_word = {ARP_HLEN_PLEN, ARP_OP_REPLY};
              req_d      = (oper == ARP_OP_REQUEST);
              if (oper == ARP_OP_REPLY) begin
                tx_drop_d = 1'b1;
                dead_d    = 1'b1;
              end
            end
            3'd2: begin
              reply_word    = our_mac_address_i[47:16];
              sha_d[47:16]  = rx_l2_bus_data_i;
            end
            3'd3: begin
              reply_word    = {our_mac_address_i[15:0], our_ip_address_i[31:16]};
              sha_d[15:0]   = rx_l2_bus_data_i[31:16];
              spa_d[31:16]  = rx_l2_bus_data_i[15:0];
            end
            3'd4: begin
              reply_word    = {our_ip_address_i[15:0], sha_q[47:32]};
              spa_d[15:0]   = rx_l2_bus_data_i[31:16];
              if (req_q) begin
                tx_dst_mac_d = sha_q;
              end
            end
            3'd5: begin
              reply_word = sha_q[31:0];
            end
            default: begin
              reply_word = spa_q;
              tpa_ok_d   = (rx_l2_bus_data_i == our_ip_address_i);
            end
          endcase
          if (rx_l2_bus_bytes_valid_i != 3'd4 || !word_ok) begin
            state_d   = StIdle;
            tx_drop_d = 1'b1;
          end else begin
            state_d   = state_q + 4'd1;
            tx_dv_d   = emit;
            tx_bv_d   = emit ? 3'd4 : 3'd0;
            tx_data_d = emit ? reply_word : '0;
          end
        end
      end
      StCommit: begin
        if (req_q && !tpa_ok_q && !dead_q) begin
          tx_drop_d = 1'b1;
          dead_d    = 1'b1;
        end
        if (rx_l2_bus_commit_i) begin
          tx_commit_d = req_q && tpa_ok_q;
          state_d     = learn_ok ? StLearn : StIdle;
        end
      end
      StLearn: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A commit before the body is complete is a truncated packet.
    if (state_q != StIdle && state_q != StLearn) begin
      abort = rx_l2_bus_drop_i || (rx_l2_bus_commit_i && state_q != StCommit);
    end
    if (abort) begin
      state_d     = StIdle;
      tx_drop_d   = 1'b1;
      tx_dv_d     = 1'b0;
      tx_bv_d     = 3'd0;
      tx_data_d   = '0;
      tx_commit_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      req_q        <= 1'b0;
      dead_q       <= 1'b0;
      tpa_ok_q     <= 1'b0;
      sha_q        <= '0;
      spa_q        <= '0;
      tx_start_q   <= 1'b0;
      tx_dv_q      <= 1'b0;
      tx_bv_q      <= 3'd0;
      tx_data_q    <= '0;
      tx_commit_q  <= 1'b0;
      tx_drop_q    <= 1'b0;
      tx_dst_mac_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      dead_q       <= dead_d;
      tpa_ok_q     <= tpa_ok_d;
      sha_q        <= sha_d;
      spa_q        <= spa_d;
      tx_start_q   <= tx_start_d;
      tx_dv_q      <= tx_dv_d;
      tx_bv_q      <= tx_bv_d;
      tx_data_q    <= tx_data_d;
      tx_commit_q  <= tx_commit_d;
      tx_drop_q    <= tx_drop_d;
      tx_dst_mac_q <= tx_dst_mac_d;
    end
  end

  assign tx_l2_bus_start_o       = tx_start_q;
  assign tx_l2_bus_data_valid_o  = tx_dv_q;
  assign tx_l2_bus_bytes_valid_o = tx_bv_q;
  assign tx_l2_bus_data_o        = tx_data_q;
  assign tx_l2_bus_commit_o      = tx_commit_q;
  assign tx_l2_bus_drop_o        = tx_drop_q;
  assign tx_l2_dst_mac_o         = tx_dst_mac_q;

  arp_cache #(
    .DEPTH   (DEPTH),
    .MAX_AGE (MAX_AGE)
  ) u_cache (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .learn_en_i    (state_q == StLearn),
    .learn_ip_i    (spa_q),
    .learn_mac_i   (sha_q),
    .lookup_en_i   (lookup_en_i),
    .lookup_ip_i   (lookup_ip_i),
    .lookup_done_o (lookup_done_o),
    .lookup_hit_o  (lookup_hit_o),
    .lookup_mac_o  (lookup_mac_o),
    .flush_i       (cache_flush_i),
    .age_tick_i    (age_tick_i)
  );

endmodule

// File: tb/tb_arp_protocol_cached.sv
// Directed bench for arp_protocol_cached with hand-computed expectations.
module tb_arp_protocol_cached;

`ifdef ARP_AGING_EN
  localparam int unsigned MaxAge = 3;
`else
  localparam int unsigned MaxAge = 300;
`endif
  localparam logic [47:0] OurMac  = 48'h02AA_BBCC_DDEE;
  localparam logic [31:0] OurIp   = 32'h0A00_0005;   // 10.0.0.5
  localparam logic [31:0] OurMask = 32'hFFFF_FF00;
  localparam logic [15:0] OpReq   = 16'h0001;
  localparam logic [15:0] OpRep   = 16'h0002;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_start, rx_dv, rx_commit, rx_drop, rx_hv, rx_is_arp;
  logic [2:0]  rx_bv;
  logic [31:0] rx_data;
  logic        tx_start, tx_dv, tx_commit, tx_drop;
  logic [2:0]  tx_bv;
  logic [31:0] tx_data;
  logic [47:0] tx_dst_mac;
  logic        lookup_en, lookup_done, lookup_hit;
  logic [31:0] lookup_ip;
  logic [47:0] lookup_mac;
  logic        cache_flush, age_tick;

  arp_protocol_cached #(
    .DEPTH   (8),
    .MAX_AGE (MaxAge)
  ) dut (
    .clk_i                    (clk),
    .rst_ni                   (rst_n),
    .our_mac_address_i        (OurMac),
    .our_ip_address_i         (OurIp),
    .our_subnet_mask_i        (OurMask),
    .rx_l2_bus_start_i        (rx_start),
    .rx_l2_bus_data_valid_i   (rx_dv),
    .rx_l2_bus_bytes_valid_i  (rx_bv),
    .rx_l2_bus_data_i         (rx_data),
    .rx_l2_bus_commit_i       (rx_commit),
    .rx_l2_bus_drop_i         (rx_drop),
    .rx_l2_headers_valid_i    (rx_hv),
    .rx_l2_ethertype_is_arp_i (rx_is_arp),
    .tx_l2_bus_start_o        (tx_start),
    .tx_l2_bus_data_valid_o   (tx_dv),
    .tx_l2_bus_bytes_valid_o  (tx_bv),
    .tx_l2_bus_data_o         (tx_data),
    .tx_l2_bus_commit_o       (tx_commit),
    .tx_l2_bus_drop_o         (tx_drop),
    .tx_l2_dst_mac_o          (tx_dst_mac),
    .lookup_en_i              (lookup_en),
    .lookup_ip_i              (lookup_ip),
    .lookup_done_o            (lookup_done),
    .lookup_hit_o             (lookup_hit),
    .lookup_mac_o             (lookup_mac),
    .cache_flush_i            (cache_flush),
    .age_tick_i               (age_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // TX monitor, sampled on the falling edge.
  logic [31:0] tx_words [8];
  int          tx_n, n_start, n_commit, n_drop, n_bad_bv;
  always @(negedge clk) begin
    if (tx_dv) begin
      if (tx_n < 8) tx_words[3'(tx_n)] <= tx_data;
      if (tx_bv != 3'd4) n_bad_bv <= n_bad_bv + 1;
      tx_n <= tx_n + 1;
    end
    if (tx_start)  n_start  <= n_start + 1;
    if (tx_commit) n_commit <= n_commit + 1;
    if (tx_drop)   n_drop   <= n_drop + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    tx_n = 0; n_start = 0; n_commit = 0; n_drop = 0; n_bad_bv = 0;
    for (int i = 0; i < 8; i++) tx_words[i] = '0;
  endtask

  task automatic start_hdr(input logic is_arp);
    rx_start = 1'b1; step(); rx_start = 1'b0;
    rx_hv = 1'b1; rx_is_arp = is_arp; step(); rx_hv = 1'b0; rx_is_arp = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [2:0] bv);
    rx_dv = 1'b1; rx_bv = bv; rx_data = w;
    step();
    rx_dv = 1'b0; rx_bv = 3'd0; rx_data = '0;
  endtask

  // Sends a full ARP body and commit; returns in the cycle after the commit.
  task automatic send_arp(input logic [15:0] oper, input logic [47:0] sha,
                          input logic [31:0] spa, input logic [31:0] tpa,
                          input int first_words);
    logic [31:0] w [7];
    w[0] = 32'h0001_0800;
    w[1] = {16'h0604, oper};
    w[2] = sha[47:16];
    w[3] = {sha[15:0], spa[31:16]};
    w[4] = {spa[15:0], 16'h0000};
    w[5] = 32'h0;
    w[6] = tpa;
    start_hdr(1'b1);
    for (int i = 0; i < first_words; i++) send_word(w[i], 3'd4);
    if (first_words == 7) begin
      rx_commit = 1'b1; step(); rx_commit = 1'b0;
    end
  endtask

  task automatic learn(input logic [31:0] ip, input logic [47:0] mac);
    send_arp(OpRep, mac, ip, OurIp, 7);
    step();
  endtask

  task automatic expect_lookup(input string tag, input logic [31:0] ip,
                               input logic exp_hit, input logic [47:0] exp_mac);
    lookup_en = 1'b1; lookup_ip = ip;
    step();
    lookup_en = 1'b0;
    check_eq({tag, "_done"}, lookup_done, 1'b1);
    check_eq({tag, "_hit"}, lookup_hit, exp_hit);
    check_eq({tag, "_mac"}, lookup_mac, exp_mac);
  endtask

  task automatic tick();
    age_tick = 1'b1; step(); age_tick = 1'b0; step();
  endtask

  logic [31:0] exp_reply [7];

  initial begin
    rst_n = 1'b0; rx_start = 0; rx_dv = 0; rx_commit = 0; rx_drop = 0; rx_hv = 0;
    rx_is_arp = 0; rx_bv = 0; rx_data = 0; lookup_en = 0; lookup_ip = 0;
    cache_flush = 0; age_tick = 0;
    clear_mon();
    repeat (3) step();
    check_eq("rst_tx_dv", tx_dv, 1'b0);
    check_eq("rst_tx_data", tx_data, 32'h0);
    check_eq("rst_tx_dst_mac", tx_dst_mac, 48'h0);
    check_eq("rst_lookup_done", lookup_done, 1'b0);
    rst_n = 1'b1;
    step();

    // Request for us from 10.0.0.9 / 02:11:22:33:44:55.
    exp_reply[0] = 32'h0001_0800;
    exp_reply[1] = 32'h0604_0002;
    exp_reply[2] = 32'h02AA_BBCC;
    exp_reply[3] = 32'hDDEE_0A00;
    exp_reply[4] = 32'h0005_0211;
    exp_reply[5] = 32'h2233_4455;
    exp_reply[6] = 32'h0A00_0009;
    clear_mon();
    send_arp(OpReq, 48'h0211_2233_4455, 32'h0A00_0009, OurIp, 7);
    step();
    expect_lookup("pkt1_lookup", 32'h0A00_0009, 1'b1, 48'h0211_2233_4455);
    check_eq("pkt1_done_one_cycle", lookup_done, 1'b1);
    step();
    check_eq("pkt1_done_drops", lookup_done, 1'b0);
    check_eq("pkt1_nwords", tx_n, 7);
    for (int i = 0; i < 7; i++) check_eq($sformatf("pkt1_word%0d", i), tx_words[i], exp_reply[i]);
    check_eq("pkt1_bv", n_bad_bv, 0);
    check_eq("pkt1_start", n_start, 1);
    check_eq("pkt1_commit", n_commit, 1);
    check_eq("pkt1_drop", n_drop, 0);
    check_eq("pkt1_dst_mac", tx_dst_mac, 48'h0211_2233_4455);

    // Request for someone else: reply cancelled at COMMIT, nothing learned.
    clear_mon();
    send_arp(OpReq, 48'h0211_2233_4466, 32'h0A00_0014, 32'h0A00_0007, 7);
    repeat (2) step();
    check_eq("pkt2_drop", n_drop, 1);
    check_eq("pkt2_commit", n_commit, 0);
    expect_lookup("pkt2_lookup", 32'h0A00_0014, 1'b0, 48'h0);

    // Reply from outside the subnet: no reply words beyond word 0, no learn.
    clear_mon();
    send_arp(OpRep, 48'h0200_0000_00C0, 32'hC0A8_0101, OurIp, 7);
    repeat (2) step();
    check_eq("rep_off_words", tx_n > 1, 1'b0);
    check_eq("rep_off_drop", n_drop, 1);
    check_eq("rep_off_commit", n_commit, 0);
    expect_lookup("rep_off_lookup", 32'hC0A8_0101, 1'b0, 48'h0);
    learn(32'h0A00_0003, 48'h0200_0000_0003);
    expect_lookup("rep_in_lookup", 32'h0A00_0003, 1'b1, 48'h0200_0000_0003);

    // Non-ARP ethertype.
    clear_mon();
    start_hdr(1'b0);
    repeat (2) step();
    check_eq("nonarp_drop", n_drop, 1);
    check_eq("nonarp_words", tx_n, 0);

    // Lookup in the flush cycle sees pre-flush contents.
    lookup_en = 1'b1; lookup_ip = 32'h0A00_0003; cache_flush = 1'b1;
    step();
    lookup_en = 1'b0; cache_flush = 1'b0;
    check_eq("flush_same_cycle_hit", lookup_hit, 1'b1);
    expect_lookup("flush_after_3", 32'h0A00_0003, 1'b0, 48'h0);
    expect_lookup("flush_after_9", 32'h0A00_0009, 1'b0, 48'h0);

    // Flush in the LEARN cycle wins.
    send_arp(OpRep, 48'h0200_0000_0028, 32'h0A00_0028, OurIp, 7);
    cache_flush = 1'b1; step(); cache_flush = 1'b0;
    expect_lookup("flush_vs_learn", 32'h0A00_0028, 1'b0, 48'h0);

    // Replacement: 10.0.0.17.. fill entries 0..7, then victim round-robin.
    for (int k = 1; k <= 9; k++) learn(32'h0A00_0010 + 32'(k), 48'h0200_0000_0100 + 48'(k));
    expect_lookup("repl9_ip1", 32'h0A00_0011, 1'b0, 48'h0);
    expect_lookup("repl9_ip2", 32'h0A00_0012, 1'b1, 48'h0200_0000_0102);
    expect_lookup("repl9_ip9", 32'h0A00_0019, 1'b1, 48'h0200_0000_0109);
    learn(32'h0A00_001A, 48'h0200_0000_010A);
    expect_lookup("repl10_ip2", 32'h0A00_0012, 1'b0, 48'h0);
    expect_lookup("repl10_ip10", 32'h0A00_001A, 1'b1, 48'h0200_0000_010A);
    learn(32'h0A00_0013, 48'h0200_0000_0F03);
    expect_lookup("relearn_ip3", 32'h0A00_0013, 1'b1, 48'h0200_0000_0F03);
    learn(32'h0A00_001B, 48'h0200_0000_010B);
    expect_lookup("repl11_ip3", 32'h0A00_0013, 1'b0, 48'h0);
    expect_lookup("repl11_ip4", 32'h0A00_0014, 1'b1, 48'h0200_0000_0104);
    expect_lookup("repl11_ip11", 32'h0A00_001B, 1'b1, 48'h0200_0000_010B);

    // Truncated packet: bytes_valid=2 in BODY_3.
    clear_mon();
    send_arp(OpReq, 48'h0200_0000_003C, 32'h0A00_003C, OurIp, 3);
    send_word(32'h003C_0A00, 3'd2);
    repeat (2) step();
    check_eq("trunc_drop", n_drop, 1);
    check_eq("trunc_commit", n_commit, 0);
    check_eq("trunc_words", tx_n, 3);
    expect_lookup("trunc_lookup", 32'h0A00_003C, 1'b0, 48'h0);

    // rx drop mid-body, then a clean request must be handled from IDLE.
    clear_mon();
    send_arp(OpReq, 48'h0200_0000_003D, 32'h0A00_003D, OurIp, 4);
    rx_drop = 1'b1; step(); rx_drop = 1'b0;
    repeat (2) step();
    check_eq("rxdrop_drop", n_drop, 1);
    check_eq("rxdrop_commit", n_commit, 0);
    expect_lookup("rxdrop_lookup", 32'h0A00_003D, 1'b0, 48'h0);
    expect_lookup("rxdrop_keep", 32'h0A00_001B, 1'b1, 48'h0200_0000_010B);
    clear_mon();
    send_arp(OpReq, 48'h0200_0000_003E, 32'h0A00_003E, OurIp, 7);
    repeat (2) step();
    check_eq("after_drop_commit", n_commit, 1);

    // Aging.
    cache_flush = 1'b1; step(); cache_flush = 1'b0;
    learn(32'h0A00_0032, 48'h0200_0000_0032);
    repeat (3) tick();
`ifdef ARP_AGING_EN
    expect_lookup("age_expired", 32'h0A00_0032, 1'b0, 48'h0);
    learn(32'h0A00_0033, 48'h0200_0000_0033);
    tick();
    send_arp(OpRep, 48'h0200_0000_0034, 32'h0A00_0033, OurIp, 7);
    age_tick = 1'b1; step(); age_tick = 1'b0; step();
    tick();
    expect_lookup("age_refreshed", 32'h0A00_0033, 1'b1, 48'h0200_0000_0034);
`else
    repeat (2) tick();
    expect_lookup("noage_alive", 32'h0A00_0032, 1'b1, 48'h0200_0000_0032);
`endif

    // Reset during BODY_5.
    learn(32'h0A00_0046, 48'h0200_0000_0046);
    send_arp(OpReq, 48'h0211_2233_4455, 32'h0A00_0047, OurIp, 5);
    rst_n = 1'b0; rx_dv = 1'b1; rx_bv = 3'd4; rx_data = 32'h0;
    lookup_en = 1'b1; lookup_ip = 32'h0A00_0046;
    step();
    rx_dv = 1'b0; rx_bv = 3'd0; lookup_en = 1'b0;
    check_eq("midrst_tx_dv", tx_dv, 1'b0);
    check_eq("midrst_tx_data", tx_data, 32'h0);
    check_eq("midrst_dst_mac", tx_dst_mac, 48'h0);
    check_eq("midrst_lookup_done", lookup_done, 1'b0);
    check_eq("midrst_lookup_mac", lookup_mac, 48'h0);
    rst_n = 1'b1;
    step();
    expect_lookup("midrst_cache_empty", 32'h0A00_0046, 1'b0, 48'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
